// File: rtl/vwb_queue.sv
`timescale 1ns/1ps
// Vector writeback request queue: filters illegal register groups, buffers legal ones,
// issues one registered writeback per cycle and publishes the pending-write mask.
module vwb_queue #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_vd,
  input  logic [2:0]        req_vlmul,
  input  logic [DATA_W-1:0] req_data,
  input  logic              wb_hold,
  input  logic              flush,
  input  logic              err_clr,
  output logic              wb_load,
  output logic [5:0]        wb_sel,
  output logic [2:0]        wb_vlmul,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       pending_mask,
  output logic              err_misalign
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic [4:0]        q_vd    [DEPTH];
  logic [1:0]        q_vlmul [DEPTH];
  logic [DATA_W-1:0] q_data  [DEPTH];

  logic empty, full, legal, accept, push, pop;

  function automatic logic [31:0] grp_mask(input logic [4:0] vd, input logic [1:0] lm);
    logic [31:0] base;
    case (lm)
      2'd0:    base = 32'h0000_0001;
      2'd1:    base = 32'h0000_0003;
      2'd2:    base = 32'h0000_000F;
      default: base = 32'h0000_00FF;
    endcase
    return base << vd;
  endfunction

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign req_ready = !full;

  // Alignment: the low vlmul bits of vd must be zero; vlmul codes 4-7 are reserved.
  assign legal  = !req_vlmul[2] &&
                  ((req_vd & ((5'd1 << req_vlmul[1:0]) - 5'd1)) == 5'd0);
  assign accept = req_valid && req_ready && !flush;
  assign push   = accept && legal;
  assign pop    = !empty && !wb_hold && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wb_load      <= 1'b0;
      wb_sel       <= '0;
      wb_vlmul     <= '0;
      wb_data      <= '0;
      err_misalign <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      wb_load <= pop;
      if (pop) begin
        wb_sel   <= {1'b0, q_vd[rd_ptr[AW-1:0]]};
        wb_vlmul <= {1'b0, q_vlmul[rd_ptr[AW-1:0]]};
        wb_data  <= q_data[rd_ptr[AW-1:0]];
      end
      if (accept && !legal)
        err_misalign <= 1'b1;
      else if (err_clr)
        err_misalign <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_vd[wr_ptr[AW-1:0]]    <= req_vd;
      q_vlmul[wr_ptr[AW-1:0]] <= req_vlmul[1:0];
      q_data[wr_ptr[AW-1:0]]  <= req_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  logic [AW-1:0] slot_off;
  always_comb begin
    pending_mask = '0;
    slot_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr[AW-1:0];
      if ({1'b0, slot_off} < count)
        pending_mask = pending_mask | grp_mask(q_vd[i], q_vlmul[i]);
    end
    if (wb_load)
      pending_mask = pending_mask | grp_mask(wb_sel[4:0], wb_vlmul[1:0]);
  end

endmodule

// File: tb/tb_vwb_queue.sv
`timescale 1ns/1ps
// Directed bench for vwb_queue: reset, latency, full/hold, illegal groups, flush,
// back-to-back throughput with pointer wrap, and asynchronous reset mid-traffic.
module tb_vwb_queue;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [4:0]        req_vd;
  logic [2:0]        req_vlmul;
  logic [DATA_W-1:0] req_data;
  logic              wb_hold, flush, err_clr;
  logic              wb_load;
  logic [5:0]        wb_sel;
  logic [2:0]        wb_vlmul;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       pending_mask;
  logic              err_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vwb_queue #(.DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vd(req_vd), .req_vlmul(req_vlmul), .req_data(req_data),
    .wb_hold(wb_hold), .flush(flush), .err_clr(err_clr),
    .wb_load(wb_load), .wb_sel(wb_sel), .wb_vlmul(wb_vlmul), .wb_data(wb_data),
    .pending_mask(pending_mask), .err_misalign(err_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [4:0] vd, input logic [2:0] lm,
                         input logic [DATA_W-1:0] d);
    req_valid = v;
    req_vd    = vd;
    req_vlmul = lm;
    req_data  = d;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (wb_load !== 1'b0 || wb_sel !== 6'd0 || wb_vlmul !== 3'd0 || wb_data !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: load=%0b sel=%0d vlmul=%0d data=%0h, want all 0",
               wb_load, wb_sel, wb_vlmul, wb_data);
    end
    n_checks++;
    if (pending_mask !== 32'h0 || err_misalign !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: mask=%h err=%0b ready=%0b, want 0/0/1",
               pending_mask, err_misalign, req_ready);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(1'b1, 5'd8, 3'd1, 128'hA5);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %0b want 1", req_ready);
    end
    tick();  // edge N: accepted
    set_req(1'b0, 5'd0, 3'd0, '0);
    n_checks++;
    if (wb_load !== 1'b0 || pending_mask !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL single_n: load=%0b mask=%h want 0/00000300", wb_load, pending_mask);
    end
    tick();  // edge N+1: popped
    n_checks++;
    if (wb_load !== 1'b1 || wb_sel !== 6'd8 || wb_vlmul !== 3'd1 || wb_data !== 128'hA5) begin
      n_fail++;
      $display("FAIL single_issue: load=%0b sel=%0d vlmul=%0d data=%0h want 1/8/1/a5",
               wb_load, wb_sel, wb_vlmul, wb_data);
    end
    n_checks++;
    if (pending_mask !== 32'h0000_0300) begin
      n_fail++; $display("FAIL single_mask_issue: got %h want 00000300", pending_mask);
    end
    tick();
    n_checks++;
    if (wb_load !== 1'b0 || pending_mask !== 32'h0 || wb_sel !== 6'd8) begin
      n_fail++;
      $display("FAIL single_after: load=%0b mask=%h sel=%0d want 0/0/8",
               wb_load, pending_mask, wb_sel);
    end
  endtask

  task automatic test_full_hold();
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 5'(i), 3'd0, 128'(i));
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_ready_%0d: got %0b want 1", i, req_ready);
      end
      tick();
    end
    set_req(1'b1, 5'd4, 3'd0, 128'd4);
    n_checks++;
    if (req_ready !== 1'b0 || pending_mask !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL full_state: ready=%0b mask=%h want 0/0000000f", req_ready, pending_mask);
    end
    tick();  // 5th request stalls
    n_checks++;
    if (req_ready !== 1'b0 || wb_load !== 1'b0 || pending_mask !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL full_stall: ready=%0b load=%0b mask=%h want 0/0/0000000f",
               req_ready, wb_load, pending_mask);
    end
    wb_hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (wb_load !== 1'b1 || wb_sel !== 6'(k)) begin
        n_fail++;
        $display("FAIL full_drain_%0d: load=%0b sel=%0d want 1/%0d", k, wb_load, wb_sel, k);
      end
      if (k == 1) set_req(1'b0, 5'd0, 3'd0, '0);
    end
    tick();
    n_checks++;
    if (wb_load !== 1'b0 || pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL full_end: load=%0b mask=%h want 0/0", wb_load, pending_mask);
    end
  endtask

  task automatic test_misalign();
    set_req(1'b1, 5'd6, 3'd2, 128'h11);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mis_ready: got %0b want 1", req_ready);
    end
    tick();
    n_checks++;
    if (err_misalign !== 1'b1 || pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_vd: err=%0b mask=%h want 1/0", err_misalign, pending_mask);
    end
    set_req(1'b1, 5'd0, 3'd5, 128'h22);
    tick();
    set_req(1'b0, 5'd0, 3'd0, '0);
    n_checks++;
    if (wb_load !== 1'b0 || pending_mask !== 32'h0 || err_misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_rsvd: load=%0b mask=%h err=%0b want 0/0/1",
               wb_load, pending_mask, err_misalign);
    end
    tick();
    n_checks++;
    if (wb_load !== 1'b0) begin
      n_fail++; $display("FAIL mis_noissue: load=%0b want 0", wb_load);
    end
    err_clr = 1'b1;
    tick();
    n_checks++;
    if (err_misalign !== 1'b0) begin
      n_fail++; $display("FAIL mis_clr: err=%0b want 0", err_misalign);
    end
    set_req(1'b1, 5'd3, 3'd1, 128'h33);
    tick();  // set and clear together
    err_clr = 1'b0;
    set_req(1'b0, 5'd0, 3'd0, '0);
    n_checks++;
    if (err_misalign !== 1'b1 || wb_load !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_setwins: err=%0b load=%0b want 1/0", err_misalign, wb_load);
    end
    tick();
    n_checks++;
    if (wb_load !== 1'b0) begin
      n_fail++; $display("FAIL mis_noissue2: load=%0b want 0", wb_load);
    end
  endtask

  task automatic test_flush();
    wb_hold = 1'b1;
    set_req(1'b1, 5'd8, 3'd3, 128'h1); tick();
    set_req(1'b1, 5'd1, 3'd0, 128'h2); tick();
    set_req(1'b1, 5'd16, 3'd2, 128'h3); tick();
    n_checks++;
    if (pending_mask !== 32'h000F_FF02) begin
      n_fail++; $display("FAIL flush_pre_mask: got %h want 000fff02", pending_mask);
    end
    set_req(1'b1, 5'd20, 3'd2, 128'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wb_hold = 1'b0;
    set_req(1'b0, 5'd0, 3'd0, '0);
    n_checks++;
    if (wb_load !== 1'b0 || pending_mask !== 32'h0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: load=%0b mask=%h ready=%0b want 0/0/1",
               wb_load, pending_mask, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wb_load !== 1'b0 || pending_mask !== 32'h0) begin
        n_fail++;
        $display("FAIL flush_drop_%0d: load=%0b mask=%h want 0/0", i, wb_load, pending_mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 5'(2 * i), 3'd0, 128'hC0 + 128'(i));
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, req_ready);
      end
      tick();
      if (wb_load === 1'b1) pulses++;
      if (i > 0) begin
        n_checks++;
        if (wb_load !== 1'b1 || wb_sel !== 6'(2 * (i - 1)) || wb_data !== 128'hC0 + 128'(i - 1)) begin
          n_fail++;
          $display("FAIL b2b_issue_%0d: load=%0b sel=%0d data=%0h want 1/%0d/%0h",
                   i - 1, wb_load, wb_sel, wb_data, 2 * (i - 1), 128'hC0 + 128'(i - 1));
        end
      end
    end
    set_req(1'b0, 5'd0, 3'd0, '0);
    tick();
    if (wb_load === 1'b1) pulses++;
    n_checks++;
    if (wb_load !== 1'b1 || wb_sel !== 6'd18 || wb_data !== 128'hC9) begin
      n_fail++;
      $display("FAIL b2b_last: load=%0b sel=%0d data=%0h want 1/18/c9", wb_load, wb_sel, wb_data);
    end
    tick();
    if (wb_load === 1'b1) pulses++;
    n_checks++;
    if (pulses !== 10 || wb_load !== 1'b0) begin
      n_fail++; $display("FAIL b2b_count: pulses=%0d load=%0b want 10/0", pulses, wb_load);
    end
  endtask

  task automatic test_reset_mid();
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 5'(8 + i), 3'd0, 128'(i));
      tick();
    end
    set_req(1'b0, 5'd0, 3'd0, '0);
    wb_hold = 1'b0;
    tick();
    wb_hold = 1'b1;
    n_checks++;
    if (wb_load !== 1'b1 || pending_mask !== 32'h0000_0700) begin
      n_fail++;
      $display("FAIL rmid_pre: load=%0b mask=%h want 1/00000700", wb_load, pending_mask);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_load !== 1'b0 || wb_sel !== 6'd0 || wb_data !== '0 || pending_mask !== 32'h0 ||
        err_misalign !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async: load=%0b sel=%0d data=%0h mask=%h err=%0b ready=%0b",
               wb_load, wb_sel, wb_data, pending_mask, err_misalign, req_ready);
    end
    #2 rst_n = 1'b1;
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wb_load !== 1'b0 || pending_mask !== 32'h0) begin
        n_fail++;
        $display("FAIL rmid_empty_%0d: load=%0b mask=%h want 0/0", i, wb_load, pending_mask);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 5'd0, 3'd0, '0);
    wb_hold = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_single();
    test_full_hold();
    test_misalign();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
